// File: rtl/caesar_stream_engine.sv
// Caesar-cipher stream engine: reads, rotates and writes back a run of characters
// held in the low byte of each word of a single-port RAM (1-cycle read latency).
module caesar_stream_engine #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic [7:0]        key,
  input  logic              decrypt,
  input  logic              raw_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [7:0]        key_q;
  logic              dec_q;
  logic              raw_q;

  logic [LEN_W-1:0]  idx_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] cap_word;

  // Offset rotation within a 26-letter alphabet; k is already reduced below 26.
  function automatic logic [7:0] shift26(input logic [7:0] o, input logic [7:0] k,
                                         input logic dec);
    logic [7:0] s;
    if (dec) begin
      s = (o < k) ? o + 8'd26 - k : o - k;
    end else begin
      s = o + k;
      if (s >= 8'd26) s = s - 8'd26;
    end
    return s;
  endfunction

  function automatic logic [7:0] xform(input logic [7:0] c, input logic [7:0] k,
                                       input logic dec, input logic raw);
    logic [7:0] r;
    if (raw)                             r = dec ? c - k : c + k;
    else if (c >= 8'd65 && c <= 8'd90)   r = 8'd65 + shift26(c - 8'd65, k, dec);
    else if (c >= 8'd97 && c <= 8'd122)  r = 8'd97 + shift26(c - 8'd97, k, dec);
    else                                 r = c;
    return r;
  endfunction

  assign idx_nxt  = idx + LEN_W'(1);
  assign addr_nxt = base_q + ADDR_W'(idx_nxt);

  // Upper bits of the word pass through; only the character byte is rotated.
  always_comb begin
    cap_word      = mem_rdata;
    cap_word[7:0] = xform(mem_rdata[7:0], key_q, dec_q, raw_q);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      key_q     <= '0;
      dec_q     <= 1'b0;
      raw_q     <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base;
            len_q    <= len;
            key_q    <= raw_mode ? key : 8'(key % 8'd26);
            dec_q    <= decrypt;
            raw_q    <= raw_mode;
            idx      <= '0;
            count    <= '0;
            mem_addr <= base;
            if (len != '0) begin
              state  <= RD;
              mem_re <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          mem_wdata <= cap_word;
          mem_we    <= 1'b1;
          state     <= WR;
        end
        WR: begin
          idx   <= idx_nxt;
          count <= count + LEN_W'(1);
          if (idx_nxt == len_q) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= RD;
            mem_re   <= 1'b1;
            mem_addr <= addr_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caesar_stream_engine.sv
// Self-checking bench for caesar_stream_engine: directed test-plan cases plus
// randomized jobs checked against a modular-arithmetic reference model.
module tb_caesar_stream_engine;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int          DEPTH  = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [7:0]        key;
  logic              decrypt;
  logic              raw_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  count;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  caesar_stream_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk1(clk1), .rst(rst), .start(start), .base(base), .len(len), .key(key),
    .decrypt(decrypt), .raw_mode(raw_mode), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .count(count)
  );

  // Synchronous single-port RAM with a backdoor write port for preloading.
  always @(posedge clk1) begin
    if (bd_we)       mem[bd_addr]  <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re)      mem_rdata     <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int c, input int k, input bit dec, input bit raw);
    int sh;
    if (raw) return 8'((dec ? c - k + 256 : c + k) % 256);
    sh = dec ? 26 - (k % 26) : (k % 26);
    if (c >= 65 && c <= 90)  return 8'(65 + (c - 65 + sh) % 26);
    if (c >= 97 && c <= 122) return 8'(97 + (c - 97 + sh) % 26);
    return 8'(c);
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_addr = ADDR_W'(a);
    bd_data = d;
    exp_mem[a] = d;
    @(negedge clk1);
    bd_we   = 1'b0;
  endtask

  // Runs one job cycle by cycle; inj>0 pulses a stray start, rcyc>0 asserts rst in that cycle.
  task automatic run_job(input int b, input int n, input int k, input bit dec, input bit raw,
                         input int inj, input int rcyc);
    int ndone, last, ecnt, mism, a;
    bit eb, ere, ewe, ed;
    ndone = (rcyc > 0) ? ((rcyc / 3 < n) ? rcyc / 3 : n) : n;
    for (int i = 0; i < ndone; i++) begin
      a = (b + i) % DEPTH;
      exp_mem[a][7:0] = ref_byte(int'(exp_mem[a][7:0]), k, dec, raw);
    end
    start    = 1'b1;
    base     = ADDR_W'(b);
    len      = LEN_W'(n);
    key      = 8'(k);
    decrypt  = dec;
    raw_mode = raw;
    last = (rcyc > 0) ? rcyc : 3 * n + 2;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge clk1);
      if (cyc == 1) start = 1'b0;
      if (inj > 0 && cyc == inj) begin
        start = 1'b1; base = ADDR_W'(b + 7); len = 8'd1; key = 8'(k + 5); decrypt = ~dec;
      end
      if (inj > 0 && cyc == inj + 1) start = 1'b0;
      eb   = (cyc <= 3 * n);
      ere  = eb && (cyc % 3 == 1);
      ewe  = eb && (cyc % 3 == 0);
      ed   = (cyc == 3 * n + 1);
      ecnt = ((cyc - 1) / 3 < n) ? (cyc - 1) / 3 : n;
      check("ctl busy/done/re/we", 32'({busy, done, mem_re, mem_we}), 32'({eb, ed, ere, ewe}));
      check("count", 32'(count), 32'(ecnt));
      if (ere || ewe) check("mem_addr", 32'(mem_addr), 32'((b + (cyc - 1) / 3) % DEPTH));
    end
    if (rcyc > 0) begin
      rst = 1'b1;
      @(negedge clk1);
      check("rst ctl", 32'({busy, done, mem_re, mem_we}), 32'(0));
      check("rst count", 32'(count), 32'(0));
      rst = 1'b0;
      @(negedge clk1);
    end
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) mism++;
    check("mem image", 32'(mism), 32'(0));
  endtask

  task automatic dir(input int b, input int n, input int k, input bit dec, input bit raw,
                     input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                     input int inj, input int rcyc);
    logic [31:0] w[3];
    logic [31:0] e[3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < n; i++) poke((b + i) % DEPTH, w[i]);
    run_job(b, n, k, dec, raw, inj, rcyc);
    for (int i = 0; i < n; i++) check("directed word", mem[(b + i) % DEPTH], e[i]);
  endtask

  initial begin
    int rb, rn, rk, r;
    logic [31:0] wd;
    rst = 1'b1; start = 1'b0; base = '0; len = '0; key = '0;
    decrypt = 1'b0; raw_mode = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    check("reset ctl", 32'({busy, done, mem_re, mem_we}), 32'(0));
    check("reset addr", 32'(mem_addr), 32'(0));
    check("reset wdata", mem_wdata, 32'(0));
    check("reset count", 32'(count), 32'(0));
    rst = 1'b0;
    @(negedge clk1);

    dir(100, 3, 3, 0, 0, 65, 66, 67, 68, 69, 70, 0, 0);
    dir(200, 3, 3, 0, 0, 88, 89, 90, 65, 66, 67, 0, 0);
    dir(210, 3, 3, 0, 0, 120, 121, 122, 97, 98, 99, 0, 0);
    dir(220, 3, 29, 0, 0, 88, 89, 90, 65, 66, 67, 0, 0);
    dir(230, 3, 3, 1, 0, 68, 69, 70, 65, 66, 67, 0, 0);
    dir(240, 1, 1, 1, 0, 65, 0, 0, 90, 0, 0, 0, 0);
    dir(250, 3, 3, 0, 0, 33, 53, 32'h7F, 33, 53, 32'h7F, 0, 0);
    dir(260, 1, 3, 0, 0, 32'hABCD0041, 0, 0, 32'hABCD0044, 0, 0, 0, 0);
    dir(270, 1, 3, 0, 1, 32'hFE, 0, 0, 32'h01, 0, 0, 0, 0);
    dir(272, 1, 3, 1, 1, 32'h01, 0, 0, 32'hFE, 0, 0, 0, 0);
    dir(274, 1, 200, 0, 1, 65, 0, 0, 9, 0, 0, 0, 0);
    dir(280, 2, 255, 0, 0, 65, 97, 0, 86, 118, 0, 0, 0);
    run_job(300, 0, 3, 0, 0, 0, 0);
    dir(1023, 2, 3, 0, 0, 65, 66, 0, 68, 69, 0, 0, 0);
    dir(400, 3, 3, 0, 0, 65, 66, 67, 68, 69, 70, 4, 0);
    dir(500, 3, 3, 0, 0, 65, 66, 67, 68, 66, 67, 0, 5);
    dir(500, 3, 3, 0, 0, 65, 66, 67, 68, 69, 70, 0, 0);

    for (int j = 0; j < 20; j++) begin
      rb = int'($urandom_range(0, DEPTH - 1));
      rn = int'($urandom_range(1, 12));
      rk = int'($urandom_range(0, 255));
      for (int i = 0; i < rn; i++) begin
        r  = int'($urandom_range(0, 2));
        wd = $urandom;
        if (r == 0)      wd[7:0] = 8'(65 + $urandom_range(0, 25));
        else if (r == 1) wd[7:0] = 8'(97 + $urandom_range(0, 25));
        poke((rb + i) % DEPTH, wd);
      end
      run_job(rb, rn, rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/caesar_stream_engine.md
# caesar_stream_engine

Hardware Caesar-cipher engine that encrypts or decrypts a run of characters in place in a word-addressed memory, replacing the software load/add/store loop on the MIPS32 core. One character is held in the low byte of each memory word. Letters rotate within their alphabet, and non-letters pass through unchanged. A raw 8-bit mode is also provided. The block is a memory master on a synchronous single-port RAM (1-cycle read latency), started by a one-cycle command pulse.

## Interface
- ADDR_W, 10, memory word-address width
- DATA_W, 32, memory word width (≥8); bits [DATA_W-1:8] are preserved on write-back
- LEN_W, 8, width of the character-count field
- clk1  in  1  clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  command pulse; accepted only in IDLE
- base  in  ADDR_W  word address of the first character, sampled on accept
- len  in  LEN_W  number of characters, sampled on accept
- key  in  8  shift amount, sampled on accept
- decrypt  in  1  0 = shift forward, 1 = shift backward; sampled on accept
- raw_mode  in  1  0 = alphabetic mod-26 mode, 1 = raw byte mod-256 mode; sampled on accept
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read strobe; data appears on mem_rdata in the following cycle
- mem_rdata  in  DATA_W  read data
- mem_we  out  1  write strobe
- mem_wdata  out  DATA_W  write data
- busy  out  1  high while a job is in progress (RD/CAP/WR states)
- done  out  1  one-cycle pulse when a job completes
- count  out  LEN_W  characters written in the current or last job

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE, start=1:
  - latch base, len, decrypt and raw_mode.
  - latch the key. In alpha mode the latched key is key mod 26 (for example, 29→3 and 255→21). In raw mode it is key unchanged.
  - clear the index and count.
  - go to RD if len≠0, else go to DONE.
- RD: mem_re=1, mem_addr=base+index (mod 2^ADDR_W). Go to CAP.
- CAP: transform mem_rdata into the wdata register. Go to WR.
- WR: mem_we=1, mem_addr=base+index, mem_wdata=wdata. Increment index and count. If index+1==len go to DONE, else go to RD.
- DONE: done=1. Go to IDLE.
- Transform of c=mem_rdata[7:0]; upper bits are copied through unchanged.
  - Alpha mode, uppercase 'A'(65)..'Z'(90): o=c-65.
    - Encrypt: o'=(o+k≥26)?o+k-26:o+k.
    - Decrypt: o'=(o<k)?o+26-k:o-k.
    - Result is 65+o'.
  - Alpha mode, lowercase 'a'(97)..'z'(122): same rule with base 97.
  - Alpha mode, any other byte: unchanged.
  - Raw mode: encrypt gives (c+k) mod 256; decrypt gives (c-k) mod 256.
- start while busy or in DONE: ignored, and does not affect the job in flight.
- Strobes: mem_re and mem_we are never high in the same cycle. No memory access occurs outside RD and WR.

## Timing
- Reset values: state=IDLE, busy=0, done=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0.
- rst mid-job: the FSM returns to IDLE on the next edge and the remaining characters are untouched. A write already issued in WR stays committed; no further write occurs.
- Cycle numbering: start is sampled on edge 0.
  - Character i occupies RD at cycle 3i+1, CAP at 3i+2 and WR at 3i+3.
  - busy is high in cycles 1..3N.
  - done is high in cycle 3N+1.
  - A new start is accepted from cycle 3N+2.
- len=0: done in cycle 1, busy never high, no memory strobes.
- Throughput: 3 cycles per character. Worst-case job (len=2^LEN_W-1) takes 3·(2^LEN_W-1)+1 cycles.
- count increments on each WR edge and holds its final value until the next accepted start.
- Address wrap: base+index wraps modulo 2^ADDR_W with no error.

## Test plan
- Encrypt, mem[100..102]=65,66,67, base=100, len=3, key=3, alpha mode → 68,69,70. done in cycle 10, count=3, exactly 3 mem_we pulses (cycles 3, 6, 9).
- Wrap: "XYZ"(88,89,90) key=3 → 65,66,67. "xyz" key=3 → 97,98,99. key=29 gives the same result as key=3.
- Decrypt: 68,69,70 key=3 with decrypt=1 → 65,66,67. 65 key=1 decrypt → 90. Passthrough: '!'(33), '5'(53) and 0x7F are unchanged, and word 0xABCD0041 key=3 → 0xABCD0044.
- Raw mode: 0xFE key=3 encrypt → 0x01. 0x01 key=3 decrypt → 0xFE. 65 key=200 encrypt → 9.
- Edge cases:
  - len=0: done in cycle 1, no strobes.
  - base=1023, len=2: writes go to addresses 1023 then 0.
  - start pulsed at cycle 4 of a running job: ignored, and the job result is unchanged.
- Reset mid-job: rst at cycle 5 of a 3-character job. Only mem[base] is modified; busy=0, done=0 and count=0 after the reset. A fresh start then runs normally.
